slice_scheduler: RTL and testbench



---
 rtl/draw_pkg.sv | 29 ++
 rtl/slice_span_calc.sv | 22 ++
 rtl/slice_scheduler.sv | 156 +++++++++++++++
 tb/tb_slice_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared drawing constants: screen geometry, default palette, scheduler state codes
// and the per-row color pick used by column renderers.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] CEIL_COLOR_DEF  = 3'b001;
  localparam logic [2:0] FLOOR_COLOR_DEF = 3'b010;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAY  = 2'd1;
  localparam logic [1:0] S_DRAW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Wall rows are top <= row < bot; an empty span (hc == 0) has no wall rows.
  function automatic logic [2:0] span_color(input logic [6:0] row,
                                            input logic [6:0] hc,
                                            input logic [6:0] top,
                                            input logic [6:0] bot,
                                            input logic [2:0] wall,
                                            input logic [2:0] ceil_c,
                                            input logic [2:0] floor_c);
    if (row < top) return ceil_c;
    if ((hc != 7'd0) && (row < bot)) return wall;
    return floor_c;
  endfunction

endpackage

// File: rtl/slice_span_calc.sv
// Vertical span of one wall slice: clamped height, first wall row, and one past the
// last wall row. Odd leftovers land in the floor because top rounds down.
module slice_span_calc
  import draw_pkg::*;
#(
  parameter int ROWS = SCREEN_H
) (
  input  logic [6:0] wall_height_i,
  output logic [6:0] hc_o,
  output logic [6:0] top_o,
  output logic [6:0] bottom_excl_o
);

  localparam logic [6:0] ROWS_L = 7'(ROWS);

  always_comb begin
    hc_o          = (wall_height_i > ROWS_L) ? ROWS_L : wall_height_i;
    top_o         = (ROWS_L - hc_o) >> 1;
    bottom_excl_o = top_o + hc_o;
  end

endmodule

// File: rtl/slice_scheduler.sv
// Per-frame column sequencer: requests one ray per column, then paints that column
// into the frame buffer one pixel per cycle. Define SLICE_SCHED_SKIP_BG_EN to paint wall rows only.
module slice_scheduler
  import draw_pkg::*;
#(
  parameter int         COLUMNS     = SCREEN_W,
  parameter int         ROWS        = SCREEN_H,
  parameter logic [2:0] CEIL_COLOR  = CEIL_COLOR_DEF,
  parameter logic [2:0] FLOOR_COLOR = FLOOR_COLOR_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       ray_req,
  output logic [7:0] ray_column,
  input  logic       ray_valid,
  input  logic [6:0] wall_height,
  input  logic [2:0] wall_color,
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic [2:0] color_out,
  output logic       draw_enable,
  output logic       busy,
  output logic       frame_done,
  output logic [1:0] dbg_state
);

  localparam logic [7:0] COL_LAST = 8'(COLUMNS - 1);
  localparam logic [6:0] ROW_LAST = 7'(ROWS - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] column_q, column_d;
  logic [6:0] row_q, row_d;
  logic [6:0] hc_q, hc_d, top_q, top_d, bot_q, bot_d;
  logic [2:0] wcolor_q, wcolor_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] color_q, color_d;
  logic       de_q, de_d;
  logic [6:0] span_hc, span_top, span_bot;
  logic       last_col, last_row;

  slice_span_calc #(.ROWS(ROWS)) u_span (
    .wall_height_i (wall_height),
    .hc_o          (span_hc),
    .top_o         (span_top),
    .bottom_excl_o (span_bot)
  );

  assign last_col = (column_q == COL_LAST);
`ifdef SLICE_SCHED_SKIP_BG_EN
  assign last_row = (row_q == (bot_q - 7'd1));
`else
  assign last_row = (row_q == ROW_LAST);
`endif

  always_comb begin
    state_d  = state_q;
    column_d = column_q;
    row_d    = row_q;
    hc_d     = hc_q;
    top_d    = top_q;
    bot_d    = bot_q;
    wcolor_d = wcolor_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RAY;
          column_d = 8'd0;
        end
      end
      S_RAY: begin
        if (ray_valid) begin
          hc_d     = span_hc;
          top_d    = span_top;
          bot_d    = span_bot;
          wcolor_d = wall_color;
`ifdef SLICE_SCHED_SKIP_BG_EN
          row_d = span_top;
          // An empty slice has nothing to paint: move straight on to the next ray.
          if (span_hc == 7'd0) begin
            if (last_col) state_d = S_DONE;
            else column_d = column_q + 8'd1;
          end else begin
            state_d = S_DRAW;
          end
`else
          row_d   = 7'd0;
          state_d = S_DRAW;
`endif
        end
      end
      S_DRAW: begin
        if (last_row) begin
          if (last_col) begin
            state_d = S_DONE;
          end else begin
            column_d = column_q + 8'd1;
            state_d  = S_RAY;
          end
        end else begin
          row_d = row_q + 7'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write-port outputs are registered from next-state so they line up with S_DRAW.
  always_comb begin
    de_d    = (state_d == S_DRAW);
    x_d     = de_d ? column_d : x_q;
    y_d     = de_d ? row_d : y_q;
    color_d = de_d ? span_color(row_d, hc_d, top_d, bot_d, wcolor_d, CEIL_COLOR, FLOOR_COLOR)
                   : 3'b000;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      column_q <= 8'd0;
      row_q    <= 7'd0;
      hc_q     <= 7'd0;
      top_q    <= 7'd0;
      bot_q    <= 7'd0;
      wcolor_q <= 3'b000;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      color_q  <= 3'b000;
      de_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      column_q <= column_d;
      row_q    <= row_d;
      hc_q     <= hc_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
      wcolor_q <= wcolor_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
      de_q     <= de_d;
    end
  end

  assign ray_req     = (state_q == S_RAY);
  assign ray_column  = column_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign color_out   = color_q;
  assign draw_enable = de_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_slice_scheduler.sv
// Bench for slice_scheduler: a ray responder with per-column tables, a pixel
// scoreboard fed by a per-frame reference model, and frame timing checks.
module tb_slice_scheduler;

  localparam int COLS = 160;
  localparam int ROWS = 120;
  localparam int W    = 18;
`ifdef SLICE_SCHED_SKIP_BG_EN
  localparam int RST_COL = 81;
`else
  localparam int RST_COL = 80;
`endif

  logic       clock, reset, start, ray_valid;
  logic [6:0] wall_height;
  logic [2:0] wall_color;
  logic       ray_req, draw_enable, busy, frame_done;
  logic [7:0] ray_column, X;
  logic [6:0] Y;
  logic [2:0] color_out;
  logic [1:0] dbg_state;

  slice_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .ray_req     (ray_req),
    .ray_column  (ray_column),
    .ray_valid   (ray_valid),
    .wall_height (wall_height),
    .wall_color  (wall_color),
    .X           (X),
    .Y           (Y),
    .color_out   (color_out),
    .draw_enable (draw_enable),
    .busy        (busy),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc_cnt = 0;
  always @(posedge clock) cyc_cnt++;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ray_req"}, 32'(ray_req), 0);
    check({tag, "_ray_column"}, 32'(ray_column), 0);
    check({tag, "_X"}, 32'(X), 0);
    check({tag, "_Y"}, 32'(Y), 0);
    check({tag, "_color"}, 32'(color_out), 0);
    check({tag, "_draw_en"}, 32'(draw_enable), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  // ---------------- reference model ----------------
  int         h_tab[COLS];
  logic [2:0] c_tab[COLS];
  int         d_tab[COLS];
  logic [W-1:0] exp_q[$];
  int         exp_frame_cycles;

  task automatic build_frame();
    int hc, top;
    bit in_wall;
    logic [2:0] col;
    exp_q.delete();
    exp_frame_cycles = 1;
    for (int c = 0; c < COLS; c++) begin
      hc  = (h_tab[c] > ROWS) ? ROWS : h_tab[c];
      top = (ROWS - hc) / 2;
      exp_frame_cycles += d_tab[c] + 1;
      for (int y = 0; y < ROWS; y++) begin
        in_wall = (y >= top) && (y < top + hc);
        col = (y < top) ? 3'b001 : (in_wall ? c_tab[c] : 3'b010);
`ifdef SLICE_SCHED_SKIP_BG_EN
        if (in_wall) begin
          exp_q.push_back({8'(c), 7'(y), col});
          exp_frame_cycles++;
        end
`else
        exp_q.push_back({8'(c), 7'(y), col});
        exp_frame_cycles++;
`endif
      end
    end
  endtask

  // ---------------- ray responder (driver) ----------------
  int resp_col, resp_wait, done_cnt, done_rel, c0;
  bit resp_acc, noise_en;
  int lr_cnt[COLS];

  task automatic clear_resp();
    resp_col  = 0;
    resp_wait = 0;
    resp_acc  = 1'b0;
    done_cnt  = 0;
    done_rel  = 0;
    for (int c = 0; c < COLS; c++) lr_cnt[c] = 0;
  endtask

  always @(negedge clock) begin
    ray_valid = 1'b0;
    if (resp_acc) begin
      resp_acc  = 1'b0;
      resp_col++;
      resp_wait = 0;
    end
    if (ray_req) begin
      if (resp_col >= COLS) begin
        check("extra_ray", 1, 0);
      end else begin
        check("ray_col", 32'(ray_column), 32'(resp_col));
        check("de_in_ray", 32'(draw_enable), 0);
        lr_cnt[resp_col]++;
        if (resp_wait >= d_tab[resp_col]) begin
          ray_valid   = 1'b1;
          wall_height = 7'(h_tab[resp_col]);
          wall_color  = c_tab[resp_col];
          resp_acc    = 1'b1;
        end else begin
          resp_wait++;
          wall_height = 7'($urandom_range(0, 127));
        end
      end
    end else if (noise_en && ($urandom_range(0, 3) == 0)) begin
      ray_valid   = 1'b1;
      wall_height = 7'($urandom_range(0, 127));
      wall_color  = 3'($urandom_range(0, 7));
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] mon_e;
  always @(negedge clock) begin
    if (draw_enable) begin
      if (exp_q.size() == 0) begin
        check("extra_write", 32'({X, Y, color_out}), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel", 32'({X, Y, color_out}), 32'(mon_e));
      end
    end else if (!reset) begin
      check("idle_color", 32'(color_out), 0);
    end
    if (ray_req || draw_enable) check("busy_active", 32'(busy), 1);
    if (frame_done) begin
      done_cnt++;
      done_rel = cyc_cnt - c0 + 1;
    end
  end

  // ---------------- frame tasks ----------------
  task automatic start_frame();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 c0 = cyc_cnt;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    for (int i = 0; i < exp_frame_cycles + 100 && done_cnt == 0; i++) @(posedge clock);
    check({tag, "_done_seen"}, 32'(done_cnt > 0), 1);
    repeat (3) @(negedge clock);
    check({tag, "_done_pulses"}, 32'(done_cnt), 1);
    check({tag, "_done_cycle"}, 32'(done_rel), 32'(exp_frame_cycles));
    check({tag, "_left_pixels"}, 32'(exp_q.size()), 0);
    check({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  task automatic report();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
  endtask

  initial begin
    repeat (90000) @(posedge clock);
    n_errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    report();
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; ray_valid = 1'b0; noise_en = 1'b0;
    wall_height = 7'd0; wall_color = 3'd0; c0 = 0;
    for (int c = 0; c < COLS; c++) begin h_tab[c] = 0; c_tab[c] = 3'd0; d_tab[c] = 0; end
    clear_resp();
    repeat (3) @(posedge clock);
    #1 check_reset_outputs("por");
    @(negedge clock) reset = 1'b0;

    // Frame 1: every column height 40, color 100, same-cycle ray answers.
    for (int c = 0; c < COLS; c++) begin h_tab[c] = 40; c_tab[c] = 3'b100; d_tab[c] = 0; end
    build_frame();
    clear_resp();
    start_frame();
    finish_frame("f1");
`ifndef SLICE_SCHED_SKIP_BG_EN
    check("f1_cycles_19361", 32'(done_rel), 19361);
`endif

    // Frame 2: random heights/colors/latencies plus the corner heights; column 7 waits 5 cycles.
    for (int c = 0; c < COLS; c++) begin
      h_tab[c] = $urandom_range(0, 127);
      c_tab[c] = 3'($urandom_range(0, 7));
      d_tab[c] = $urandom_range(0, 3);
    end
    h_tab[0] = 127; h_tab[1] = 0; h_tab[2] = 41; h_tab[3] = 120; h_tab[4] = 121;
    d_tab[7] = 5;
    build_frame();
    clear_resp();
    noise_en = 1'b1;
    start_frame();
    fork
      finish_frame("f2");
      begin
        for (int i = 0; i < 3000 && resp_col < 7; i++) @(negedge clock);
        check("f2_reach_col7", 32'(resp_col >= 7), 1);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock) start = 1'b0;
      end
    join
    noise_en = 1'b0;
    check("f2_lr_col7", 32'(lr_cnt[7]), 6);
    for (int c = 0; c < COLS; c++) check("f2_lr", 32'(lr_cnt[c]), 32'(d_tab[c] + 1));

    // Frame 3: reset in the middle of a column.
    for (int c = 0; c < COLS; c++) begin
`ifdef SLICE_SCHED_SKIP_BG_EN
      h_tab[c] = (c % 2 == 1) ? 20 : 0;
`else
      h_tab[c] = $urandom_range(0, 127);
`endif
      c_tab[c] = 3'($urandom_range(0, 7));
      d_tab[c] = 0;
    end
    h_tab[RST_COL] = 20;
    build_frame();
    clear_resp();
    start_frame();
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 20000 && !hit; i++) begin
        @(negedge clock);
        if (draw_enable && X == 8'(RST_COL) && Y == 7'd50) hit = 1'b1;
      end
      check("f3_reach_rst_point", 32'(hit), 1);
    end
    reset = 1'b1;
    @(posedge clock);
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    clear_resp();
    @(negedge clock) reset = 1'b0;

    // Frame 4: restart after the reset begins at column 0; stop after two columns.
    build_frame();
    clear_resp();
    start_frame();
    for (int i = 0; i < 1000 && resp_col < 2; i++) @(negedge clock);
    check("f4_two_columns", 32'(resp_col >= 2), 1);
    reset = 1'b1;
    @(posedge clock);
    #1 check_reset_outputs("endrst");
    exp_q.delete();
    clear_resp();
    @(negedge clock) reset = 1'b0;
    repeat (2) @(negedge clock);

    report();
    $finish;
  end

endmodule
